subckt_stim_probe: RTL and testbench
====================================

// Module: subckt_stim_probe
// PURPOSE
//   Drive end of the 4-input power sub-circuit harness. Generates pseudo-random
//   stimulus on the sub-circuit inputs n_1..n_4 and samples its single output.
//   Checks each response against a built-in golden model and counts input/output
//   toggles and mismatches over a fixed window. Results go out on a valid/ready handshake.
// PARAMETERS
//   WINDOW  256      samples per run, 1..2**CNT_W-1
//   CNT_W   16       width of every result counter
//   SEED    16'hACE1 LFSR load value; SEED==0 is replaced by 16'hACE1
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      run request; sampled only in IDLE
//   stim_o       out  4      registered stimulus; bit0=n_1, bit1=n_2, bit2=n_3, bit3=n_4
//   resp_i       in   1      sub-circuit output for the current stim_o (combinational path)
//   busy         out  1      high in RUN and DONE
//   res_valid    out  1      results valid (DONE state)
//   res_ready    in   1      results consumed when res_valid & res_ready
//   in_toggles   out  CNT_W  sum of popcount(stim_o ^ previous stim_o)
//   out_toggles  out  CNT_W  count of resp_i changes between samples
//   mismatches   out  CNT_W  count of samples where resp_i != golden(stim_o)
//   samples      out  CNT_W  samples taken in the run, equals WINDOW when valid
// BEHAVIOUR
//   Reset (async): state=IDLE, LFSR=SEED (or substitute), stim_o=0,
//     every counter=0, busy=0, res_valid=0.
//   Golden: g = (n_4 | (n_1^n_3)) & (n_1 | (n_2 & (n_1^n_3))).
//   LFSR: 16-bit Fibonacci, shift left, fb = q[15]^q[13]^q[12]^q[10].
//     The LFSR advances only in RUN. stim_o <= next LFSR [3:0].
//   FSM IDLE -> RUN on start.
//     On that edge: stim_o <= LFSR-seed[3:0], clear all counters, LFSR <= seed.
//     In IDLE, stim_o holds its last value and start is the only input honoured.
//   RUN, every edge (sample k = samples):
//     if resp_i != g(stim_o), mismatches++.
//     if k>0: in_toggles += popcount(stim_o ^ stim_prev).
//     if k>0: out_toggles += (resp_i != resp_prev).
//     stim_prev <= stim_o; resp_prev <= resp_i; samples++; stim_o/LFSR advance.
//     When samples reaches WINDOW on this edge, go to DONE.
//     The LFSR does not advance on the final edge.
//     Run length: exactly WINDOW cycles. The first sample adds no toggle counts.
//   DONE: res_valid=1 and all counters frozen.
//     On res_valid & res_ready: go to IDLE, res_valid drops next cycle.
//     Counter values stay readable in IDLE until the next start.
//     start is ignored in RUN and DONE; it is not queued.
//   Counters saturate at 2**CNT_W-1 and never wrap. in_toggles may add up to 4 per cycle.
//   Reset mid-RUN or mid-DONE aborts the run. No partial result is presented.
//   Latency: start edge -> res_valid high is WINDOW+1 cycles.
// TESTING
//   1 Reset: assert rst_n=0 mid-clock -> stim_o=0, res_valid=0, busy=0, counters=0
//     immediately, without waiting for a clock edge.
//   2 Loopback: resp_i driven by an ideal golden model, WINDOW=256 -> mismatches=0,
//     samples=256; in_toggles and out_toggles equal the scoreboard counts.
//   3 Stuck-at-0 on resp_i -> mismatches = scoreboard count of g=1 samples,
//     out_toggles=0. Spot checks: g(0000)=0, g(n_1=1,n_3=0)=1.
//   4 Backpressure: hold res_ready=0 for 50 cycles in DONE -> res_valid held and
//     counters stable; a start pulse is ignored; ready=1 -> IDLE the next cycle.
//   5 Abort: rst_n low at sample 100 -> state IDLE with all outputs cleared.
//     A new start then repeats the identical stimulus sequence from the seed.
//   6 Edge params: WINDOW=1 -> samples=1, toggles=0, res_valid 2 cycles after start.
//     CNT_W=4 with inverted resp and WINDOW=15 -> mismatches=15.
//     in_toggles saturates at 15.

Source files
------------

// File: rtl/subckt_stim_probe.sv
// Stimulus generator and response checker for a 4-input power sub-circuit.
// Drives LFSR stimulus for WINDOW samples, checks each response against a golden model, then holds the results until they are read.
module subckt_stim_probe #(
  parameter int          WINDOW = 256,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       stim_o,
  input  logic             resp_i,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] in_toggles,
  output logic [CNT_W-1:0] out_toggles,
  output logic [CNT_W-1:0] mismatches,
  output logic [CNT_W-1:0] samples
);

  // Results handshake: a result set transfers on a rising edge where
  // res_valid & res_ready; res_valid and the counters stay stable until then.

  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       stim_q, stim_d;
  logic [3:0]       stim_prev_q, stim_prev_d;
  logic             resp_prev_q, resp_prev_d;
  logic [CNT_W-1:0] in_tog_q, in_tog_d;
  logic [CNT_W-1:0] out_tog_q, out_tog_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic [CNT_W-1:0] samp_q, samp_d;

  logic [15:0] lfsr_nxt;
  logic        golden;
  logic [2:0]  pop_cnt;
  logic        last_sample;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign lfsr_nxt    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign golden      = (stim_q[3] | (stim_q[0] ^ stim_q[2])) &
                       (stim_q[0] | (stim_q[1] & (stim_q[0] ^ stim_q[2])));
  assign pop_cnt     = 3'(stim_q[0] ^ stim_prev_q[0]) + 3'(stim_q[1] ^ stim_prev_q[1]) +
                       3'(stim_q[2] ^ stim_prev_q[2]) + 3'(stim_q[3] ^ stim_prev_q[3]);
  assign last_sample = (samp_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      stim_q      <= 4'h0;
      stim_prev_q <= 4'h0;
      resp_prev_q <= 1'b0;
      in_tog_q    <= '0;
      out_tog_q   <= '0;
      mism_q      <= '0;
      samp_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      stim_q      <= stim_d;
      stim_prev_q <= stim_prev_d;
      resp_prev_q <= resp_prev_d;
      in_tog_q    <= in_tog_d;
      out_tog_q   <= out_tog_d;
      mism_q      <= mism_d;
      samp_q      <= samp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_sample) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    stim_d      = stim_q;
    stim_prev_d = stim_prev_q;
    resp_prev_d = resp_prev_q;
    in_tog_d    = in_tog_q;
    out_tog_d   = out_tog_q;
    mism_d      = mism_q;
    samp_d      = samp_q;
    if (state_q == IDLE && start) begin
      lfsr_d    = SEED_EFF;
      stim_d    = SEED_EFF[3:0];
      in_tog_d  = '0;
      out_tog_d = '0;
      mism_d    = '0;
      samp_d    = '0;
    end else if (state_q == RUN) begin
      if (resp_i != golden) mism_d = sat_add(mism_q, 3'd1);
      // The first sample has no predecessor, so it contributes no toggles.
      if (samp_q != '0) begin
        in_tog_d = sat_add(in_tog_q, pop_cnt);
        if (resp_i != resp_prev_q) out_tog_d = sat_add(out_tog_q, 3'd1);
      end
      stim_prev_d = stim_q;
      resp_prev_d = resp_i;
      samp_d      = sat_add(samp_q, 3'd1);
      if (!last_sample) begin
        lfsr_d = lfsr_nxt;
        stim_d = lfsr_nxt[3:0];
      end
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
  end

  assign stim_o      = stim_q;
  assign in_toggles  = in_tog_q;
  assign out_toggles = out_tog_q;
  assign mismatches  = mism_q;
  assign samples     = samp_q;

endmodule

// File: tb/tb_subckt_stim_probe.sv
// Bench for subckt_stim_probe: three instances (main, WINDOW=1, 4-bit counters)
// checked against a bench-side stimulus/response model through expected queues.
module tb_subckt_stim_probe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_v [3];
  logic ready_v [3];
  int   mode_v  [3];
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  stim_a, stim_b, stim_c;
  logic        resp_a, resp_b, resp_c;
  logic        busy_a, busy_b, busy_c;
  logic        valid_a, valid_b, valid_c;
  logic [15:0] it_a, ot_a, mm_a, sp_a;
  logic [15:0] it_b, ot_b, mm_b, sp_b;
  logic [3:0]  it_c, ot_c, mm_c, sp_c;

  logic [63:0] exp_q [$];
  logic [3:0]  stim_q [$];

  function automatic logic gold(input logic [3:0] s);
    return (s[3] | (s[0] ^ s[2])) & (s[0] | (s[1] & (s[0] ^ s[2])));
  endfunction

  // mode 0: ideal sub-circuit, 1: stuck-at-0, 2: inverted output
  function automatic logic resp_of(input int m, input logic [3:0] s);
    case (m)
      0:       return gold(s);
      1:       return 1'b0;
      default: return ~gold(s);
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign resp_a = resp_of(mode_v[0], stim_a);
  assign resp_b = resp_of(mode_v[1], stim_b);
  assign resp_c = resp_of(mode_v[2], stim_c);

  subckt_stim_probe #(.WINDOW(256), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stim_o(stim_a), .resp_i(resp_a),
    .busy(busy_a), .res_valid(valid_a), .res_ready(ready_v[0]), .in_toggles(it_a),
    .out_toggles(ot_a), .mismatches(mm_a), .samples(sp_a));

  subckt_stim_probe #(.WINDOW(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stim_o(stim_b), .resp_i(resp_b),
    .busy(busy_b), .res_valid(valid_b), .res_ready(ready_v[1]), .in_toggles(it_b),
    .out_toggles(ot_b), .mismatches(mm_b), .samples(sp_b));

  subckt_stim_probe #(.WINDOW(15), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stim_o(stim_c), .resp_i(resp_c),
    .busy(busy_c), .res_valid(valid_c), .res_ready(ready_v[2]), .in_toggles(it_c),
    .out_toggles(ot_c), .mismatches(mm_c), .samples(sp_c));

  function automatic logic [3:0] stim_of(input int id);
    case (id)
      0:       return stim_a;
      1:       return stim_b;
      default: return stim_c;
    endcase
  endfunction

  function automatic logic valid_of(input int id);
    case (id)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [63:0] res_of(input int id);
    case (id)
      0:       return {it_a, ot_a, mm_a, sp_a};
      1:       return {it_b, ot_b, mm_b, sp_b};
      default: return {12'h0, it_c, 12'h0, ot_c, 12'h0, mm_c, 12'h0, sp_c};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input int win, input int cw, input int mode);
    logic [15:0] l;
    logic [3:0]  s, p;
    logic        r, rp;
    int          it, ot, mm, sat;
    it = 0; ot = 0; mm = 0; p = 4'h0; rp = 1'b0;
    sat = (1 << cw) - 1;
    l = 16'hACE1;
    for (int k = 0; k < win; k++) begin
      s = l[3:0];
      stim_q.push_back(s);
      r = resp_of(mode, s);
      if (r != gold(s)) mm++;
      if (k > 0) begin
        it += $countones(s ^ p);
        if (r != rp) ot++;
      end
      p = s;
      rp = r;
      l = lfsr_step(l);
    end
    if (it > sat) it = sat;
    if (ot > sat) ot = sat;
    if (mm > sat) mm = sat;
    exp_q.push_back({16'(it), 16'(ot), 16'(mm), 16'(win)});
  endtask

  task automatic run(input int id, input int mode, input int win, input int cw,
                     input int abort_at, input int hold);
    int          cyc;
    logic [63:0] e;
    mode_v[id] = mode;
    stim_q.delete();
    model_push(win, cw, mode);
    ready_v[id] = 1'b0;
    @(negedge clk);
    start_v[id] = 1'b1;
    @(negedge clk);
    start_v[id] = 1'b0;
    cyc = 1;
    while (!valid_of(id) && cyc <= win + 5) begin
      if (stim_q.size() > 0) chk("stim", 64'(stim_of(id)), 64'(stim_q.pop_front()));
      if (abort_at > 0 && cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_stim", 64'(stim_of(id)), 64'd0);
        chk("abort_busy", 64'(busy_of(id)), 64'd0);
        chk("abort_valid", 64'(valid_of(id)), 64'd0);
        chk("abort_counters", res_of(id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        return;
      end
      @(negedge clk);
      cyc++;
    end
    chk("valid_seen", 64'(valid_of(id)), 64'd1);
    chk("latency", 64'(cyc), 64'(win + 1));
    e = exp_q.pop_front();
    chk("results", res_of(id), e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_v[id] = (i == 10);
      chk("bp_valid", 64'(valid_of(id)), 64'd1);
    end
    start_v[id] = 1'b0;
    if (hold > 0) chk("bp_frozen", res_of(id), e);
    ready_v[id] = 1'b1;
    @(negedge clk);
    ready_v[id] = 1'b0;
    chk("rel_valid", 64'(valid_of(id)), 64'd0);
    chk("rel_busy", 64'(busy_of(id)), 64'd0);
    @(negedge clk);
    chk("no_queue_busy", 64'(busy_of(id)), 64'd0);
    chk("idle_readable", res_of(id), e);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      ready_v[i] = 1'b0;
      mode_v[i]  = 0;
    end
    #12;
    chk("rst_stim", 64'(stim_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_counters", res_of(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 0, 256, 16, 100, 0);
    run(0, 0, 256, 16, 0, 0);
    run(0, 1, 256, 16, 0, 50);
    run(1, 0, 1, 16, 0, 0);
    run(2, 2, 15, 4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
